// File: rtl/fpmult_stream_ctrl.sv
// rtl/fpmult_stream_ctrl.sv - valid/ready streaming wrapper around the FPmult multiplier
// Input FIFO -> credit-gated issue -> fixed-latency tag pipe -> result FIFO.
module fpmult_stream_ctrl #(
    parameter int IDEPTH   = 4,
    parameter int RDEPTH   = 4,
    parameter int MULT_LAT = 1,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mult_m,
    output logic [31:0]      mult_q,
    input  logic [31:0]      mult_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int IAW = $clog2(IDEPTH);
    localparam int RAW = $clog2(RDEPTH);
    localparam int ICW = $clog2(IDEPTH + 1);
    localparam int RCW = $clog2(RDEPTH + 1);
    localparam int PL  = MULT_LAT + 1;

    logic [31:0]      ia_mem [IDEPTH];
    logic [31:0]      ib_mem [IDEPTH];
    logic [TAG_W-1:0] it_mem [IDEPTH];
    logic [IAW-1:0]   iwr, ird;
    logic [ICW-1:0]   icount;

    logic [PL-1:0]    pipe_v;
    logic [TAG_W-1:0] pipe_tag [PL];

    logic [31:0]      rd_mem [RDEPTH];
    logic [TAG_W-1:0] rt_mem [RDEPTH];
    logic [RAW-1:0]   rwr, rrd;
    logic [RCW-1:0]   rcount;
    logic [RCW-1:0]   credits;

    logic push, issue, capture, pop;

    assign in_ready  = (icount != ICW'(IDEPTH));
    assign out_valid = (rcount != '0);
    assign out_data  = rd_mem[rrd];
    assign out_tag   = rt_mem[rrd];
    assign busy      = (icount != '0) || (credits != '0);

    assign push    = in_valid && in_ready;
    // Credits reserve a result slot at issue time, so capture can never overflow.
    assign issue   = (icount != '0) && (credits < RCW'(RDEPTH));
    assign capture = pipe_v[PL-1];
    assign pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            iwr     <= '0;
            ird     <= '0;
            icount  <= '0;
            mult_m  <= '0;
            mult_q  <= '0;
            pipe_v  <= '0;
            rwr     <= '0;
            rrd     <= '0;
            rcount  <= '0;
            credits <= '0;
        end else begin
            if (push) begin
                iwr <= iwr + IAW'(1);
            end
            if (issue) begin
                ird    <= ird + IAW'(1);
                mult_m <= ia_mem[ird];
                mult_q <= ib_mem[ird];
            end
            icount <= icount + ICW'(push) - ICW'(issue);
            pipe_v <= {pipe_v[PL-2:0], issue};
            if (capture) begin
                rwr <= rwr + RAW'(1);
            end
            if (pop) begin
                rrd <= rrd + RAW'(1);
            end
            rcount  <= rcount + RCW'(capture) - RCW'(pop);
            credits <= credits + RCW'(issue) - RCW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ia_mem[iwr] <= in_a;
            ib_mem[iwr] <= in_b;
            it_mem[iwr] <= in_tag;
        end
        pipe_tag[0] <= it_mem[ird];
        for (int i = 1; i < PL; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
        if (!rst && capture) begin
            rd_mem[rwr] <= mult_result;
            rt_mem[rwr] <= pipe_tag[PL-1];
        end
    end
endmodule
